// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam int STARVE_LIMIT_DEFAULT = 2;

  // A limit of 0 still needs one bit of counter storage.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while a fetch was waiting.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = cnt_width(LIMIT);

  logic [CW-1:0] cnt_r;

  assign sat = (cnt_r == CW'(LIMIT));

  // Counter register; clear has priority, increments stop at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && !sat) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory, one transaction in flight.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  input  logic [3:0]    dm_be,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [31:0]   dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          stall_f,
  output logic          stall_m
);

  state_t state_r;
  state_t state_s;
  logic   discard_r;
  logic   discard_s;
  owner_t win_s;
  logic   if_elig_s;
  logic   inc_s;
  logic   clr_s;
  logic   sat_s;

  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_s),
    .clr   (clr_s),
    .sat   (sat_s)
  );

  // State and flush-discard registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      discard_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      discard_r <= discard_s;
    end
  end

  // Winner selection, memory muxing, response routing and stalls.
  always_comb begin
    state_s   = state_r;
    discard_s = discard_r;
    win_s     = OWN_NONE;
    if_elig_s = if_req & ~if_flush;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = 32'd0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = 32'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    mem_be    = 4'd0;
    stall_f   = 1'b0;
    stall_m   = 1'b0;
    inc_s     = 1'b0;
    clr_s     = 1'b0;
    if (reset) begin
      state_s   = IDLE;
      discard_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // Data normally wins; a fetch that has waited STARVE_LIMIT grants goes first.
          if (dm_req && !(sat_s && if_elig_s)) begin
            win_s = OWN_DM;
          end else if (if_elig_s) begin
            win_s = OWN_IF;
          end else begin
            win_s = OWN_NONE;
          end
          case (win_s)
            OWN_DM: begin
              mem_req   = 1'b1;
              mem_we    = dm_we;
              mem_addr  = dm_addr;
              mem_wdata = dm_wdata;
              mem_be    = dm_be;
            end
            OWN_IF: begin
              mem_req  = 1'b1;
              mem_addr = if_addr;
            end
            default: begin
              mem_req = 1'b0;
            end
          endcase
          if (mem_req && mem_gnt) begin
            if (win_s == OWN_DM) begin
              dm_gnt  = 1'b1;
              state_s = WAIT_D;
            end else begin
              if_gnt  = 1'b1;
              state_s = WAIT_I;
            end
          end else begin
            state_s = IDLE;
          end
        end
        WAIT_I: begin
          if (mem_rvalid) begin
            if_rvalid = ~discard_r & ~if_flush;
            if_rdata  = if_rvalid ? mem_rdata : 32'd0;
            state_s   = IDLE;
            discard_s = 1'b0;
          end else if (if_flush) begin
            discard_s = 1'b1;
          end else begin
            discard_s = discard_r;
          end
        end
        WAIT_D: begin
          if (mem_rvalid) begin
            dm_rvalid = 1'b1;
            dm_rdata  = mem_rdata;
            state_s   = IDLE;
          end else begin
            state_s = WAIT_D;
          end
        end
        default: begin
          state_s   = IDLE;
          discard_s = 1'b0;
        end
      endcase
      stall_f = ((if_req & ~if_gnt) | ((state_r == WAIT_I) & ~if_rvalid)) & ~discard_r;
      stall_m = (dm_req & ~dm_gnt) | ((state_r == WAIT_D) & ~dm_rvalid);
      inc_s   = dm_gnt & if_req & ~if_flush;
      clr_s   = if_gnt | ((state_r == IDLE) & ~if_req);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the memory and scoreboards responses.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be, mem_be;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_f, stall_m;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  mem_arbiter #(.STARVE_LIMIT(2), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every forwarded response must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && (if_rvalid || dm_rvalid)) begin
      if (sb_q.size() == 0) begin
        chk32("unexpected_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk1("sb_if_rvalid", if_rvalid, e.is_if);
        chk1("sb_dm_rvalid", dm_rvalid, !e.is_if);
        chk32("sb_rdata", e.is_if ? if_rdata : dm_rdata, e.data);
      end
    end
  end

  initial begin
    logic [5:0] order;
    order = 6'b100100;

    // Reset with everything active: all outputs must stay low.
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h0; if_flush = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_if_gnt", if_gnt, 1'b0);
    chk1("rst_dm_gnt", dm_gnt, 1'b0);
    chk1("rst_if_rvalid", if_rvalid, 1'b0);
    chk1("rst_dm_rvalid", dm_rvalid, 1'b0);
    chk1("rst_stall_f", stall_f, 1'b0);
    chk1("rst_stall_m", stall_m, 1'b0);
    step();
    reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    step();

    // Single fetch, one-cycle memory.
    if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1;
    @(negedge clk);
    chk1("f_mem_req", mem_req, 1'b1);
    chk32("f_mem_addr", mem_addr, 32'h100);
    chk1("f_mem_we", mem_we, 1'b0);
    chk1("f_if_gnt", if_gnt, 1'b1);
    chk1("f_stall_f_t0", stall_f, 1'b0);
    step();
    if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    sb_q.push_back('{1'b1, 32'hDEAD_BEEF});
    @(negedge clk);
    chk1("f_if_rvalid_t1", if_rvalid, 1'b1);
    chk32("f_if_rdata_t1", if_rdata, 32'hDEAD_BEEF);
    chk1("f_wait_mem_req", mem_req, 1'b0);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk1("f_stall_f_t2", stall_f, 1'b0);
    chk1("f_if_rvalid_t2", if_rvalid, 1'b0);
    chk32("f_if_rdata_t2", if_rdata, 32'h0);
    step();

    // A flushed fetch is not eligible.
    if_req = 1'b1; if_flush = 1'b1; mem_gnt = 1'b1;
    @(negedge clk);
    chk1("fl_mem_req", mem_req, 1'b0);
    chk1("fl_if_gnt", if_gnt, 1'b0);
    step();
    if_req = 1'b0; if_flush = 1'b0; mem_gnt = 1'b0;
    step();

    // Both requesting continuously: D, D, I, D, D, I.
    if_addr = 32'h200; dm_addr = 32'h300;
    for (int i = 0; i < 6; i++) begin
      if_req = 1'b1; dm_req = 1'b1; mem_gnt = 1'b1;
      @(negedge clk);
      chk1("ord_if_gnt", if_gnt, order[i]);
      chk1("ord_dm_gnt", dm_gnt, !order[i]);
      chk32("ord_addr", mem_addr, order[i] ? 32'h200 : 32'h300);
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 + 32'(i);
      sb_q.push_back('{order[i], 32'hA000_0000 + 32'(i)});
      @(negedge clk);
      chk1("ord_bubble", if_gnt | dm_gnt, 1'b0);
      step();
      mem_rvalid = 1'b0;
    end
    if_req = 1'b0; dm_req = 1'b0; mem_gnt = 1'b0;
    step();

    // Data write with a slow ack; fetch blocked until the cycle after.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h55AA_55AA; dm_be = 4'hF; mem_gnt = 1'b1;
    @(negedge clk);
    chk1("w_dm_gnt", dm_gnt, 1'b1);
    chk1("w_mem_we", mem_we, 1'b1);
    chk32("w_mem_addr", mem_addr, 32'h40);
    chk32("w_mem_wdata", mem_wdata, 32'h55AA_55AA);
    chk32("w_mem_be", {28'd0, mem_be}, 32'hF);
    step();
    dm_req = 1'b0; dm_we = 1'b0; if_req = 1'b1; if_addr = 32'h500;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("w_stall_m", stall_m, 1'b1);
      chk1("w_if_blocked", if_gnt, 1'b0);
      chk1("w_stall_f", stall_f, 1'b1);
      step();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_A5A5;
    sb_q.push_back('{1'b0, 32'h0000_A5A5});
    @(negedge clk);
    chk1("w_ack_stall_m", stall_m, 1'b0);
    chk1("w_ack_if_gnt", if_gnt, 1'b0);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk1("w_after_if_gnt", if_gnt, 1'b1);
    chk32("w_after_addr", mem_addr, 32'h500);
    step();
    if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
    sb_q.push_back('{1'b1, 32'hCAFE_0001});
    step();
    mem_rvalid = 1'b0;
    step();

    // Flush while waiting; response two cycles later is dropped.
    if_req = 1'b1; if_addr = 32'h600; mem_gnt = 1'b1;
    @(negedge clk);
    chk1("d_if_gnt", if_gnt, 1'b1);
    step();
    if_req = 1'b0; if_flush = 1'b1; mem_gnt = 1'b0;
    @(negedge clk);
    chk1("d_flush_rvalid", if_rvalid, 1'b0);
    chk1("d_flush_stall_f", stall_f, 1'b1);
    step();
    if_flush = 1'b0;
    @(negedge clk);
    chk1("d_disc_stall_f", stall_f, 1'b0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk1("d_drop_rvalid", if_rvalid, 1'b0);
    chk32("d_drop_rdata", if_rdata, 32'h0);
    step();
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h700; mem_gnt = 1'b1;
    @(negedge clk);
    chk1("d_next_if_gnt", if_gnt, 1'b1);
    chk32("d_next_addr", mem_addr, 32'h700);
    step();
    if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    sb_q.push_back('{1'b1, 32'h0BAD_F00D});
    step();
    mem_rvalid = 1'b0;
    step();

    // Flush in the same cycle as the response.
    if_req = 1'b1; if_addr = 32'h800; mem_gnt = 1'b1;
    @(negedge clk);
    chk1("s_if_gnt", if_gnt, 1'b1);
    step();
    if_req = 1'b0; mem_gnt = 1'b0; if_flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_0000;
    @(negedge clk);
    chk1("s_same_rvalid", if_rvalid, 1'b0);
    step();
    if_flush = 1'b0; mem_rvalid = 1'b0;
    step();

    // Build up starve count, reset mid-WAIT_D, stray response afterwards.
    if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h900; dm_addr = 32'hA00; mem_gnt = 1'b1;
    @(negedge clk);
    chk1("r_pre_dm_gnt1", dm_gnt, 1'b1);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h2222_0001;
    sb_q.push_back('{1'b0, 32'h2222_0001});
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk1("r_pre_dm_gnt2", dm_gnt, 1'b1);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk1("r_mid_mem_req", mem_req, 1'b0);
    chk1("r_mid_dm_gnt", dm_gnt, 1'b0);
    chk1("r_mid_stall_m", stall_m, 1'b0);
    chk1("r_mid_stall_f", stall_f, 1'b0);
    step();
    reset = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    chk1("r_stray_dm_rvalid", dm_rvalid, 1'b0);
    chk1("r_stray_if_rvalid", if_rvalid, 1'b0);
    chk1("r_stray_mem_req", mem_req, 1'b1);
    step();
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    chk1("r_post_dm_gnt", dm_gnt, 1'b1);
    chk1("r_post_if_gnt", if_gnt, 1'b0);
    step();
    if_req = 1'b0; dm_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_0001;
    sb_q.push_back('{1'b0, 32'h5A5A_0001});
    step();
    mem_rvalid = 1'b0;
    step();

    chk32("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
